turnstile_fare_controller: RTL
==============================

# turnstile_fare_controller

Fare-collection controller that drives the turnstile lock FSM from the payment side. Accumulates coin credit and issues a single-cycle coin pulse to the turnstile once the fare is met. It then tracks the turnstile's locked status through one complete passage, deducts the fare, and returns any excess credit as change. Sits between the coin-sensor front end and the turnstile's coin/locked interface.

## Interface
- FARE, 25: credit units charged per passage; must be ≥1 and ≤ 2^CREDIT_W−1
- COIN_W, 4: width of coin value bus
- CREDIT_W, 8: width of credit accumulator and change bus
- TIMEOUT, 1000: cycles to wait for unlock before re-issuing coin pulse; ≥2
- i_Clk  in  1  system clock, all logic on rising edge
- i_Rst_L  in  1  synchronous, active-low reset
- i_Coin_Valid  in  1  one-cycle pulse, coin inserted
- i_Coin_Value  in  COIN_W  coin value, qualified by i_Coin_Valid
- i_Cancel  in  1  one-cycle pulse, refund request
- i_Locked  in  1  turnstile status, 1 = locked
- o_Coin  out  1  one-cycle pulse to turnstile coin input
- o_Coin_Reject  out  1  one-cycle pulse, coin not credited
- o_Credit  out  CREDIT_W  current credit
- o_Change_Valid  out  1  one-cycle pulse, change/refund issued
- o_Change_Value  out  CREDIT_W  change amount, valid with o_Change_Valid, else 0
- o_Busy  out  1  high in GRANT, WAIT_UNLOCK, WAIT_LOCK, REFUND

## Operation
- States: IDLE, COLLECT, GRANT, WAIT_UNLOCK, WAIT_LOCK, REFUND.
- IDLE (credit = 0):
  - Valid nonzero coin → credit = value, go to COLLECT.
  - Zero-value coin → reject.
  - Cancel ignored.
- COLLECT:
  - Valid coin: sum computed at CREDIT_W+1 bits. If the sum > 2^CREDIT_W−1 or value = 0 → reject, credit unchanged. Otherwise credit += value.
  - Registered credit ≥ FARE → GRANT.
  - Cancel → REFUND with change = full credit.
  - Coin and cancel in the same cycle: cancel wins, coin rejected.
- GRANT: o_Coin high for this single cycle, timeout counter cleared → WAIT_UNLOCK.
- WAIT_UNLOCK:
  - i_Locked = 0 → WAIT_LOCK.
  - Counter reaches TIMEOUT−1 with i_Locked still 1 → GRANT (re-issue pulse). Unlimited retries.
- WAIT_LOCK: i_Locked = 1 → credit −= FARE. Remainder > 0 → REFUND, else IDLE.
- REFUND: o_Change_Valid = 1, o_Change_Value = credit, credit → 0 → IDLE.
- In GRANT, WAIT_UNLOCK, WAIT_LOCK, REFUND:
  - Every valid coin is rejected.
  - Cancel is ignored.
- All outputs are registered.

## Timing
- Reset (i_Rst_L = 0 at an edge):
  - State IDLE.
  - Credit, timeout counter and all outputs = 0.
  - Applies from any state, including mid-passage; credit is discarded and no change is issued.
- Coin sampled at edge N: o_Credit updated after N.
- If the coin completes the fare: o_Coin high for the cycle after edge N+1, then deasserts.
- o_Coin_Reject asserted for one cycle after the sampling edge.
- Passage complete: i_Locked 0→1 sampled at edge M.
  - o_Credit shows the remainder after M.
  - o_Change_Valid high for the cycle after M+1, if remainder > 0.
- Cancel sampled at edge C in COLLECT: o_Change_Valid high for the cycle after C+1.
- Re-issued o_Coin pulses are separated by TIMEOUT+1 cycles.
- i_Locked is assumed synchronous to i_Clk.

## Structure
- Shared package turnstile_pkg holds:
  - state encoding constants (3-bit, six states);
  - the LOCKED/UNLOCKED status constants shared with the turnstile FSM.
- Sub-module turnstile_timeout_counter:
  - clear and enable inputs;
  - TIMEOUT parameter;
  - expired flag output.
- Credit arithmetic and the FSM live in the top module.

## Test plan
- Coins 10, 10, 5 (FARE 25) → credit 10, 20, 25; one o_Coin pulse; drive i_Locked 0 then 1 → credit 0, no change pulse, back to IDLE.
- Coins 10, 10, 10 → o_Coin; after passage, o_Change_Valid with value 5, credit 0.
- Coin 10, then cancel and coin 5 in the same cycle → o_Coin_Reject, o_Change_Value 10, no o_Coin.
- Credit 250, coin 10 → reject, credit stays 250; state moves to GRANT because 250 ≥ 25.
- Hold i_Locked = 1 after the grant → o_Coin re-issued every TIMEOUT+1 cycles; coins during the wait rejected.
- Assert i_Rst_L = 0 in WAIT_LOCK with credit 30 → state IDLE, credit 0, o_Busy 0, no change pulse.

Source files
------------

// File: rtl/turnstile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : turnstile_pkg
// Description : Shared definitions for the turnstile fare-collection slice.
//               Holds the 3-bit state encoding of the fare controller FSM,
//               the lock-status constants shared with the turnstile lock FSM,
//               and a small helper that classifies states as busy.
// Contents    : state_t           - 3-bit state type
//               c_ST_*            - six state encodings
//               c_LOCKED          - i_Locked level meaning "turnstile locked"
//               c_UNLOCKED        - i_Locked level meaning "turnstile free"
//               is_busy()         - 1 for GRANT/WAIT_UNLOCK/WAIT_LOCK/REFUND
// Revision    : 1.0 - initial release
// ============================================================================
package turnstile_pkg;

  typedef logic [2:0] state_t;

  localparam state_t c_ST_IDLE        = 3'd0;
  localparam state_t c_ST_COLLECT     = 3'd1;
  localparam state_t c_ST_GRANT       = 3'd2;
  localparam state_t c_ST_WAIT_UNLOCK = 3'd3;
  localparam state_t c_ST_WAIT_LOCK   = 3'd4;
  localparam state_t c_ST_REFUND      = 3'd5;

  // Status levels on the turnstile's locked output.
  localparam logic c_LOCKED   = 1'b1;
  localparam logic c_UNLOCKED = 1'b0;

  // States in which the controller refuses new coins and ignores cancel.
  function automatic logic is_busy(input state_t s);
    return (s == c_ST_GRANT)       ||
           (s == c_ST_WAIT_UNLOCK) ||
           (s == c_ST_WAIT_LOCK)   ||
           (s == c_ST_REFUND);
  endfunction

endpackage
`default_nettype wire

// File: rtl/turnstile_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : turnstile_timeout_counter
// Description : Saturating cycle counter used to bound the wait for the
//               turnstile to unlock after a coin pulse. The count is cleared
//               by i_Clear, advances on i_Enable and stops at TIMEOUT-1.
//               o_Expired is high while the count sits at TIMEOUT-1.
// Parameters  : TIMEOUT   - cycles counted before expiry (>= 2)
// Ports       : i_Clk     in  1  clock, rising edge
//               i_Rst_L   in  1  synchronous active-low reset
//               i_Clear   in  1  return count to zero (priority over enable)
//               i_Enable  in  1  advance count by one
//               o_Expired out 1  count has reached TIMEOUT-1
// Revision    : 1.0 - initial release
// ============================================================================
module turnstile_timeout_counter #(
  parameter int TIMEOUT = 1000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Expired
);

  localparam int c_CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_count;

  // Saturate at the last value so a long enable never wraps back to a
  // non-expired count.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_count <= '0;
    end else if (i_Clear) begin
      r_count <= '0;
    end else if (i_Enable && (r_count != c_LAST)) begin
      r_count <= r_count + c_ONE;
    end
  end

  assign o_Expired = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/turnstile_fare_controller.sv
`default_nettype none
// ============================================================================
// Module      : turnstile_fare_controller
// Description : Payment-side controller for the turnstile lock FSM. Adds up
//               coin credit, issues a one-cycle coin pulse once the fare is
//               covered, follows the turnstile through unlock and relock,
//               deducts the fare and pays back any surplus as change. A
//               cancel while collecting refunds the full credit. If the
//               turnstile fails to unlock within TIMEOUT cycles the coin
//               pulse is re-issued, without limit.
// Parameters  : FARE      - credit charged per passage (1 .. 2^CREDIT_W-1)
//               COIN_W    - coin value bus width (<= CREDIT_W)
//               CREDIT_W  - credit accumulator / change bus width
//               TIMEOUT   - unlock wait before re-issuing the pulse (>= 2)
// Ports       : i_Clk          in  1         clock, rising edge
//               i_Rst_L        in  1         synchronous active-low reset
//               i_Coin_Valid   in  1         coin inserted (one cycle)
//               i_Coin_Value   in  COIN_W    coin value
//               i_Cancel       in  1         refund request (one cycle)
//               i_Locked       in  1         turnstile status, 1 = locked
//               o_Coin         out 1         coin pulse to the turnstile
//               o_Coin_Reject  out 1         coin was not credited
//               o_Credit       out CREDIT_W  current credit
//               o_Change_Valid out 1         change / refund issued
//               o_Change_Value out CREDIT_W  change amount, 0 when not valid
//               o_Busy         out 1         passage or refund in progress
//               All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module turnstile_fare_controller
  import turnstile_pkg::*;
#(
  parameter int FARE     = 25,
  parameter int COIN_W   = 4,
  parameter int CREDIT_W = 8,
  parameter int TIMEOUT  = 1000
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Coin_Valid,
  input  logic [COIN_W-1:0]   i_Coin_Value,
  input  logic                i_Cancel,
  input  logic                i_Locked,
  output logic                o_Coin,
  output logic                o_Coin_Reject,
  output logic [CREDIT_W-1:0] o_Credit,
  output logic                o_Change_Valid,
  output logic [CREDIT_W-1:0] o_Change_Value,
  output logic                o_Busy
);

  localparam logic [CREDIT_W-1:0] c_FARE = CREDIT_W'(FARE);

  // --------------------------------------------------------------------------
  // Registered state and outputs
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_coin;
  logic                r_reject;
  logic                r_chg_valid;
  logic [CREDIT_W-1:0] r_chg_value;
  logic                r_busy;

  // --------------------------------------------------------------------------
  // Combinational next values
  // --------------------------------------------------------------------------
  state_t              w_state_nxt;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic                w_coin_nxt;
  logic                w_reject_nxt;
  logic                w_chg_valid_nxt;
  logic [CREDIT_W-1:0] w_chg_value_nxt;
  logic                w_busy_nxt;

  // --------------------------------------------------------------------------
  // Credit arithmetic
  // --------------------------------------------------------------------------
  logic [CREDIT_W:0]   w_value_ext;
  logic [CREDIT_W:0]   w_sum;
  logic                w_value_nz;
  logic                w_coin_fits;
  logic                w_fare_met;
  logic [CREDIT_W-1:0] w_remainder;
  logic                w_timeout;

  // The sum carries one extra bit so an overflowing coin is detected rather
  // than silently wrapping the accumulator.
  assign w_value_ext = {{(CREDIT_W + 1 - COIN_W){1'b0}}, i_Coin_Value};
  assign w_sum       = {1'b0, r_credit} + w_value_ext;
  assign w_value_nz  = (i_Coin_Value != '0);
  assign w_coin_fits = w_value_nz && !w_sum[CREDIT_W];
  assign w_fare_met  = (r_credit >= c_FARE);
  // Only reached after a grant, so credit is never below the fare here.
  assign w_remainder = r_credit - c_FARE;

  // --------------------------------------------------------------------------
  // Unlock timeout: restarted by every coin pulse, runs while waiting
  // --------------------------------------------------------------------------
  turnstile_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_Clk     (i_Clk),
    .i_Rst_L   (i_Rst_L),
    .i_Clear   (r_state == c_ST_GRANT),
    .i_Enable  (r_state == c_ST_WAIT_UNLOCK),
    .o_Expired (w_timeout)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (i_Coin_Valid && w_value_nz) begin
          w_state_nxt = c_ST_COLLECT;
        end
      end
      c_ST_COLLECT: begin
        // A refund request takes precedence over granting passage.
        if (i_Cancel) begin
          w_state_nxt = c_ST_REFUND;
        end else if (w_fare_met) begin
          w_state_nxt = c_ST_GRANT;
        end
      end
      c_ST_GRANT: begin
        w_state_nxt = c_ST_WAIT_UNLOCK;
      end
      c_ST_WAIT_UNLOCK: begin
        if (i_Locked == c_UNLOCKED) begin
          w_state_nxt = c_ST_WAIT_LOCK;
        end else if (w_timeout) begin
          w_state_nxt = c_ST_GRANT;
        end
      end
      c_ST_WAIT_LOCK: begin
        if (i_Locked == c_LOCKED) begin
          w_state_nxt = (w_remainder != '0) ? c_ST_REFUND : c_ST_IDLE;
        end
      end
      c_ST_REFUND: begin
        w_state_nxt = c_ST_IDLE;
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output / datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    w_credit_nxt    = r_credit;
    w_reject_nxt    = 1'b0;
    w_chg_valid_nxt = 1'b0;
    w_chg_value_nxt = '0;
    case (r_state)
      c_ST_IDLE: begin
        // Credit is zero here, so the coin value simply becomes the credit.
        if (i_Coin_Valid) begin
          if (w_value_nz) begin
            w_credit_nxt = w_value_ext[CREDIT_W-1:0];
          end else begin
            w_reject_nxt = 1'b1;
          end
        end
      end
      c_ST_COLLECT: begin
        if (i_Coin_Valid) begin
          if (!i_Cancel && w_coin_fits) begin
            w_credit_nxt = w_sum[CREDIT_W-1:0];
          end else begin
            w_reject_nxt = 1'b1;
          end
        end
      end
      c_ST_WAIT_LOCK: begin
        w_reject_nxt = i_Coin_Valid;
        if (i_Locked == c_LOCKED) begin
          w_credit_nxt = w_remainder;
        end
      end
      c_ST_REFUND: begin
        w_reject_nxt    = i_Coin_Valid;
        w_chg_valid_nxt = 1'b1;
        w_chg_value_nxt = r_credit;
        w_credit_nxt    = '0;
      end
      default: begin
        // GRANT and WAIT_UNLOCK: credit frozen, coins refused.
        w_reject_nxt = i_Coin_Valid;
      end
    endcase
  end

  // The coin pulse and busy flag are registered from the next state so they
  // line up exactly with the cycles spent in GRANT / the busy states.
  assign w_coin_nxt = (w_state_nxt == c_ST_GRANT);
  assign w_busy_nxt = is_busy(w_state_nxt);

  // --------------------------------------------------------------------------
  // Output and credit registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_credit    <= '0;
      r_coin      <= 1'b0;
      r_reject    <= 1'b0;
      r_chg_valid <= 1'b0;
      r_chg_value <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_credit    <= w_credit_nxt;
      r_coin      <= w_coin_nxt;
      r_reject    <= w_reject_nxt;
      r_chg_valid <= w_chg_valid_nxt;
      r_chg_value <= w_chg_value_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign o_Coin         = r_coin;
  assign o_Coin_Reject  = r_reject;
  assign o_Credit       = r_credit;
  assign o_Change_Valid = r_chg_valid;
  assign o_Change_Value = r_chg_value;
  assign o_Busy         = r_busy;

endmodule
`default_nettype wire
